// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and types for the CDB arbiter slice.
// The width constants mirror the core-wide values from const.v.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_ID_WID = 3;
  localparam int unsigned DATA_WID   = 32;
  localparam int unsigned ADDR_WID   = 32;

  typedef enum logic {
    SrcAlu = 1'b0,
    SrcLsb = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Small skid FIFO holding one producer's pending results for the CDB.
// Depth must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [Width-1:0]             push_data,
  output logic [Width-1:0]             head,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Payload storage needs no reset; count_q guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter putting ALU and LSB results onto the single CDB.
// Each source has a skid FIFO; an empty FIFO lets a live result bypass straight to the bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned ROB_ID_W   = ROB_ID_WID,
  parameter int unsigned DATA_W     = DATA_WID,
  parameter int unsigned ADDR_W     = ADDR_WID,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                alu_is_jump,
  input  logic [ADDR_W-1:0]   alu_jump_pc,
  input  logic                lsb_valid,
  output logic                lsb_ready,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_data,
  output logic                cdb_valid,
  output logic                cdb_src,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_data,
  output logic                cdb_is_jump,
  output logic [ADDR_W-1:0]   cdb_jump_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AluW = ROB_ID_W + DATA_W + 1 + ADDR_W;
  localparam int unsigned LsbW = ROB_ID_W + DATA_W;

  logic [CntW-1:0] alu_count, lsb_count;
  logic [AluW-1:0] alu_head, alu_live, alu_cand_pl;
  logic [LsbW-1:0] lsb_head, lsb_live, lsb_cand_pl;
  logic            active, alu_nonempty, lsb_nonempty;
  logic            alu_xfer, lsb_xfer, alu_cand, lsb_cand;
  logic            alu_push, alu_pop, lsb_push, lsb_pop;
  logic            gnt_valid;
  cdb_src_e        gnt_src, last_grant_q;

  logic                cdb_valid_q;
  cdb_src_e            cdb_src_q;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_data_q, cdb_data_d;
  logic                cdb_is_jump_q, cdb_is_jump_d;
  logic [ADDR_W-1:0]   cdb_jump_pc_q, cdb_jump_pc_d;

  assign active       = rdy & ~rollback;
  assign alu_nonempty = (alu_count != '0);
  assign lsb_nonempty = (lsb_count != '0);
  // Ready looks only at the registered count, so a full FIFO refuses even when popping.
  assign alu_ready    = active & (alu_count < CntW'(FIFO_DEPTH));
  assign lsb_ready    = active & (lsb_count < CntW'(FIFO_DEPTH));
  assign alu_xfer     = alu_valid & alu_ready;
  assign lsb_xfer     = lsb_valid & lsb_ready;

  assign alu_live    = {alu_rob_id, alu_data, alu_is_jump, alu_jump_pc};
  assign lsb_live    = {lsb_rob_id, lsb_data};
  assign alu_cand    = alu_nonempty | alu_xfer;
  assign lsb_cand    = lsb_nonempty | lsb_xfer;
  assign alu_cand_pl = alu_nonempty ? alu_head : alu_live;
  assign lsb_cand_pl = lsb_nonempty ? lsb_head : lsb_live;

  assign gnt_valid = active & (alu_cand | lsb_cand);

  always_comb begin
    gnt_src = SrcAlu;
    if (alu_cand && lsb_cand) begin
      gnt_src = (last_grant_q == SrcAlu) ? SrcLsb : SrcAlu;
    end else if (lsb_cand) begin
      gnt_src = SrcLsb;
    end
  end

  // A granted bypass candidate goes straight to the bus and is not enqueued.
  assign alu_pop  = gnt_valid & (gnt_src == SrcAlu) & alu_nonempty;
  assign lsb_pop  = gnt_valid & (gnt_src == SrcLsb) & lsb_nonempty;
  assign alu_push = alu_xfer & ~(gnt_valid & (gnt_src == SrcAlu) & ~alu_nonempty);
  assign lsb_push = lsb_xfer & ~(gnt_valid & (gnt_src == SrcLsb) & ~lsb_nonempty);

  cdb_fifo #(
    .Width (AluW),
    .Depth (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (rollback),
    .push      (alu_push),
    .pop       (alu_pop),
    .push_data (alu_live),
    .head      (alu_head),
    .count     (alu_count)
  );

  cdb_fifo #(
    .Width (LsbW),
    .Depth (FIFO_DEPTH)
  ) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (rollback),
    .push      (lsb_push),
    .pop       (lsb_pop),
    .push_data (lsb_live),
    .head      (lsb_head),
    .count     (lsb_count)
  );

  always_comb begin
    {cdb_rob_id_d, cdb_data_d, cdb_is_jump_d, cdb_jump_pc_d} = alu_cand_pl;
    if (gnt_src == SrcLsb) begin
      {cdb_rob_id_d, cdb_data_d} = lsb_cand_pl;
      cdb_is_jump_d              = 1'b0;
      cdb_jump_pc_d              = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q   <= 1'b0;
      cdb_src_q     <= SrcAlu;
      cdb_rob_id_q  <= '0;
      cdb_data_q    <= '0;
      cdb_is_jump_q <= 1'b0;
      cdb_jump_pc_q <= '0;
      last_grant_q  <= SrcLsb;
    end else if (rollback) begin
      cdb_valid_q  <= 1'b0;
      last_grant_q <= SrcLsb;
    end else if (rdy) begin
      cdb_valid_q <= gnt_valid;
      if (gnt_valid) begin
        cdb_src_q     <= gnt_src;
        cdb_rob_id_q  <= cdb_rob_id_d;
        cdb_data_q    <= cdb_data_d;
        cdb_is_jump_q <= cdb_is_jump_d;
        cdb_jump_pc_q <= cdb_jump_pc_d;
        last_grant_q  <= gnt_src;
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_src     = cdb_src_q;
  assign cdb_rob_id  = cdb_rob_id_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_is_jump = cdb_is_jump_q;
  assign cdb_jump_pc = cdb_jump_pc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus hand-written
// sequences for reset state, exact payload values and asynchronous reset.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        alu_valid, alu_ready, alu_is_jump;
  logic [2:0]  alu_rob_id;
  logic [31:0] alu_data, alu_jump_pc;
  logic        lsb_valid, lsb_ready;
  logic [2:0]  lsb_rob_id;
  logic [31:0] lsb_data;
  logic        cdb_valid, cdb_src, cdb_is_jump;
  logic [2:0]  cdb_rob_id;
  logic [31:0] cdb_data, cdb_jump_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .ROB_ID_W   (3),
    .DATA_W     (32),
    .ADDR_W     (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rob_id  (alu_rob_id),
    .alu_data    (alu_data),
    .alu_is_jump (alu_is_jump),
    .alu_jump_pc (alu_jump_pc),
    .lsb_valid   (lsb_valid),
    .lsb_ready   (lsb_ready),
    .lsb_rob_id  (lsb_rob_id),
    .lsb_data    (lsb_data),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .cdb_rob_id  (cdb_rob_id),
    .cdb_data    (cdb_data),
    .cdb_is_jump (cdb_is_jump),
    .cdb_jump_pc (cdb_jump_pc)
  );

  // One row per clock: inputs, expected readies before the edge, expected bus after it.
  typedef struct {
    logic       do_rst;
    logic       rdy;
    logic       rb;
    logic       av;
    logic [2:0] aid;
    logic       lv;
    logic [2:0] lid;
    logic       er_a;
    logic       er_l;
    logic       ev;
    logic       esrc;
    logic [2:0] eid;
    logic       chkp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic do_rst, input logic rdy_v, input logic rb,
                              input logic av, input logic [2:0] aid,
                              input logic lv, input logic [2:0] lid,
                              input logic er_a, input logic er_l,
                              input logic ev, input logic esrc, input logic [2:0] eid,
                              input logic chkp);
    vec_t v;
    v.do_rst = do_rst; v.rdy = rdy_v; v.rb = rb;
    v.av = av; v.aid = aid; v.lv = lv; v.lid = lid;
    v.er_a = er_a; v.er_l = er_l;
    v.ev = ev; v.esrc = esrc; v.eid = eid; v.chkp = chkp;
    return v;
  endfunction

  // Payload encoding derived from the tag so every result is distinguishable.
  function automatic logic [31:0] adata(input logic [2:0] id);
    return 32'hA000_0000 | {29'd0, id};
  endfunction
  function automatic logic [31:0] apc(input logic [2:0] id);
    return 32'h0000_0100 + {29'd0, id};
  endfunction
  function automatic logic [31:0] ldata(input logic [2:0] id);
    return 32'hB000_0000 | {29'd0, id};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rollback    = 1'b0;
    alu_valid   = 1'b0;
    alu_rob_id  = '0;
    alu_data    = '0;
    alu_is_jump = 1'b0;
    alu_jump_pc = '0;
    lsb_valid   = 1'b0;
    lsb_rob_id  = '0;
    lsb_data    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [2:0] id;
    if (v.do_rst) do_reset();
    rdy         = v.rdy;
    rollback    = v.rb;
    alu_valid   = v.av;
    alu_rob_id  = v.aid;
    alu_data    = adata(v.aid);
    alu_is_jump = v.aid[0];
    alu_jump_pc = apc(v.aid);
    lsb_valid   = v.lv;
    lsb_rob_id  = v.lid;
    lsb_data    = ldata(v.lid);
    #1;
    chk($sformatf("v%0d alu_ready", i), {31'd0, alu_ready}, {31'd0, v.er_a});
    chk($sformatf("v%0d lsb_ready", i), {31'd0, lsb_ready}, {31'd0, v.er_l});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d cdb_valid", i), {31'd0, cdb_valid}, {31'd0, v.ev});
    if (v.ev || v.chkp) begin
      id = v.eid;
      chk($sformatf("v%0d cdb_src", i), {31'd0, cdb_src}, {31'd0, v.esrc});
      chk($sformatf("v%0d cdb_rob_id", i), {29'd0, cdb_rob_id}, {29'd0, id});
      chk($sformatf("v%0d cdb_data", i), cdb_data, v.esrc ? ldata(id) : adata(id));
      chk($sformatf("v%0d cdb_is_jump", i), {31'd0, cdb_is_jump},
          {31'd0, v.esrc ? 1'b0 : id[0]});
      chk($sformatf("v%0d cdb_jump_pc", i), cdb_jump_pc, v.esrc ? 32'd0 : apc(id));
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();

    // Reset state, then one idle cycle.
    do_reset();
    chk("rst alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst lsb_ready", {31'd0, lsb_ready}, 32'd1);
    chk("rst cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst cdb_src", {31'd0, cdb_src}, 32'd0);
    chk("rst cdb_rob_id", {29'd0, cdb_rob_id}, 32'd0);
    chk("rst cdb_data", cdb_data, 32'd0);
    chk("rst cdb_is_jump", {31'd0, cdb_is_jump}, 32'd0);
    chk("rst cdb_jump_pc", cdb_jump_pc, 32'd0);
    @(posedge clk);
    #1;
    chk("idle cdb_valid", {31'd0, cdb_valid}, 32'd0);

    // Single ALU result with exact payload, broadcast the next cycle only.
    alu_valid   = 1'b1;
    alu_rob_id  = 3'd3;
    alu_data    = 32'h0000_1234;
    alu_is_jump = 1'b1;
    alu_jump_pc = 32'h0000_0100;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("single cdb_valid", {31'd0, cdb_valid}, 32'd1);
    chk("single cdb_src", {31'd0, cdb_src}, 32'd0);
    chk("single cdb_rob_id", {29'd0, cdb_rob_id}, 32'd3);
    chk("single cdb_data", cdb_data, 32'h0000_1234);
    chk("single cdb_is_jump", {31'd0, cdb_is_jump}, 32'd1);
    chk("single cdb_jump_pc", cdb_jump_pc, 32'h0000_0100);
    @(posedge clk);
    #1;
    chk("single pulse end", {31'd0, cdb_valid}, 32'd0);
    chk("single data held", cdb_data, 32'h0000_1234);

    // Asynchronous reset mid-cycle clears the bus before the next edge.
    alu_valid  = 1'b1;
    alu_rob_id = 3'd5;
    alu_data   = 32'h0000_5555;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("arst pre cdb_valid", {31'd0, cdb_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("arst cdb_data", cdb_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Same-cycle ALU id1 / LSB id2 after reset.
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 2, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2, 1));
    // Sustained dual traffic for 10 cycles, then drain.
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 2, 1, 2, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 3, 1, 3, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 4, 1, 3, 0, 1, 1, 0, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 4, 1, 4, 1, 0, 1, 1, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 5, 1, 4, 0, 1, 1, 0, 3, 1));
    vecs.push_back(mk(0, 1, 0, 1, 5, 1, 5, 1, 0, 1, 1, 3, 1));
    vecs.push_back(mk(0, 1, 0, 1, 6, 1, 5, 0, 1, 1, 0, 4, 1));
    vecs.push_back(mk(0, 1, 0, 1, 6, 1, 6, 1, 0, 1, 1, 4, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 5, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 6, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 6, 1));
    // Queue results, then rollback with new inputs: nothing pending ever appears.
    vecs.push_back(mk(1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 2, 1, 2, 1, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // Broadcast in flight, rdy low for 3 cycles, then drain resumes.
    vecs.push_back(mk(0, 1, 0, 1, 4, 1, 4, 1, 1, 1, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 5, 1, 5, 0, 0, 1, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 5, 1, 5, 0, 0, 1, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 1, 5, 1, 5, 0, 0, 1, 0, 4, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 4, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 4, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
